// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the AHB-to-APB master controller.
//   state_e      : controller FSM states
//   HRESP_OKAY / HRESP_ERROR : AHB response encodings driven on hresp
package apb_master_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Watchdog for the APB ACCESS phase: counts consecutive ACCESS cycles
// with pready low and flags the cycle in which the TIMEOUT-th such cycle
// occurs. Built into the top only when APB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_access   : controller is in ACCESS this cycle
//   pready      : APB ready from the selected slave
//   expired     : this is the TIMEOUT-th consecutive wait cycle
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_access,
  input  logic pready,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = in_access && !pready && (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d   = cnt_q;
    if (!in_access || pready) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// AHB-side request to APB master controller. Accepts one transfer at a
// time, runs the APB SETUP/ACCESS sequence on the one-hot selected slave
// and returns data or a two-cycle AHB ERROR response.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT
// consecutive cycles with pready low (reported as an ERROR response).
// Ports:
//   hclk, hreset           : clock, synchronous active-high reset
//   valid, hwrite, haddr   : AHB request, direction, address
//   hwdata                 : write data, one cycle after the address
//   slvsel                 : one-hot slave decode
//   hrdata, hreadyout, hresp : AHB response (hresp 1 = ERROR)
//   paddr, pwdata, pwrite, psel, penable : APB request
//   prdata, pready, pslverr  : APB response
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLV    = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSLV-1:0]   slvsel,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic              to_expired;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (hclk),
    .rst       (hreset),
    .in_access (state_q == ACCESS),
    .pready    (pready),
    .expired   (to_expired)
  );
`else
  assign to_expired = 1'b0;
  // TIMEOUT only has meaning when the watchdog is built in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    sel_d     = sel_q;
    hrdata    = '0;
    hreadyout = 1'b0;
    hresp     = HRESP_OKAY;
    psel      = '0;
    penable   = 1'b0;

    unique case (state_q)
      IDLE: begin
        hreadyout = 1'b1;
      end
      WWAIT: begin
        pwdata_d = hwdata;
        state_d  = SETUP;
      end
      SETUP: begin
        psel    = sel_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
        if (pready) begin
          if (pslverr) begin
            state_d = ERR1;
          end else begin
            hreadyout = 1'b1;
            hrdata    = prdata;
            state_d   = IDLE;
          end
        end else if (to_expired) begin
          state_d = ERR1;
        end
      end
      ERR1: begin
        hresp   = HRESP_ERROR;
        state_d = ERR2;
      end
      ERR2: begin
        hresp     = HRESP_ERROR;
        hreadyout = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the per-state next state, which gives
    // back-to-back transfers out of a completing ACCESS or ERR2.
    if (valid && hreadyout) begin
      paddr_d  = haddr;
      pwrite_d = hwrite;
      sel_d    = slvsel;
      if (!$onehot(slvsel)) begin
        state_d = ERR1;
      end else if (hwrite) begin
        state_d = WWAIT;
      end else begin
        state_d = SETUP;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
    end
  end

  assign paddr  = paddr_q;
  assign pwdata = pwdata_q;
  assign pwrite = pwrite_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  slvsel;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];

  apb_master_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NSLV    (3),
    .TIMEOUT (4)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .valid     (valid),
    .hwrite    (hwrite),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .slvsel    (slvsel),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic err, input logic chk_data, input logic [31:0] data);
    resp_t r;
    r.err      = err;
    r.chk_data = chk_data;
    r.data     = data;
    exp_q.push_back(r);
  endtask

  // Response monitor: every completing ACCESS or ERR2 cycle is a response.
  initial begin
    resp_t e;
    forever begin
      @(negedge hclk);
      if (!hreset && hreadyout && (penable || hresp)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual hresp=%0b hrdata=%0h required=no response", hresp, hrdata);
        end else begin
          e = exp_q.pop_front();
          chk("resp_hresp", 64'(hresp), 64'(e.err));
          if (e.chk_data) chk("resp_hrdata", 64'(hrdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    slvsel = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_hreadyout", 64'(hreadyout), 64'd1);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);

    // Read accepted in the first cycle out of reset
    @(posedge hclk); #1;
    hreset = 1'b0; valid = 1'b1; hwrite = 1'b0; haddr = 32'h10; slvsel = 3'b010;
    #1;
    chk("rd_accept_hready", 64'(hreadyout), 64'd1);
    push(1'b0, 1'b1, 32'hA5A5A5A5);
    cyc();
    valid = 1'b0; prdata = 32'hA5A5A5A5; pready = 1'b1;
    #1;
    chk("rd_setup_psel", 64'(psel), 64'h2);
    chk("rd_setup_penable", 64'(penable), 64'd0);
    chk("rd_setup_paddr", 64'(paddr), 64'h10);
    chk("rd_setup_hready", 64'(hreadyout), 64'd0);
    cyc(); #1;
    chk("rd_access_psel", 64'(psel), 64'h2);
    chk("rd_access_penable", 64'(penable), 64'd1);
    chk("rd_access_hready", 64'(hreadyout), 64'd1);
    chk("rd_access_hrdata", 64'(hrdata), 64'hA5A5A5A5);
    cyc(); #1;
    chk("rd_idle_psel", 64'(psel), 64'd0);

    // Write with three wait cycles
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h20; slvsel = 3'b001; pready = 1'b0;
    push(1'b0, 1'b0, 32'h0);
    cyc();
    valid = 1'b0; hwdata = 32'h12345678;
    #1;
    chk("wr_wwait_hready", 64'(hreadyout), 64'd0);
    chk("wr_wwait_psel", 64'(psel), 64'd0);
    cyc();
    hwdata = 32'hDEADBEEF;
    #1;
    chk("wr_setup_psel", 64'(psel), 64'h1);
    chk("wr_setup_pwdata", 64'(pwdata), 64'h12345678);
    chk("wr_setup_pwrite", 64'(pwrite), 64'd1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_wait_pwdata", 64'(pwdata), 64'h12345678);
      chk("wr_wait_paddr", 64'(paddr), 64'h20);
      chk("wr_wait_pwrite", 64'(pwrite), 64'd1);
      chk("wr_wait_penable", 64'(penable), 64'd1);
      chk("wr_wait_hready", 64'(hreadyout), 64'd0);
      cyc();
    end
    pready = 1'b1;
    #1;
    chk("wr_done_hready", 64'(hreadyout), 64'd1);
    cyc();

    // Back-to-back reads
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h30; slvsel = 3'b100; prdata = 32'h11111111;
    push(1'b0, 1'b1, 32'h11111111);
    cyc();
    haddr = 32'h34; slvsel = 3'b001;
    #1;
    chk("b2b_setup1_paddr", 64'(paddr), 64'h30);
    chk("b2b_setup1_psel", 64'(psel), 64'h4);
    cyc(); #1;
    chk("b2b_access1_hready", 64'(hreadyout), 64'd1);
    chk("b2b_access1_hrdata", 64'(hrdata), 64'h11111111);
    push(1'b0, 1'b1, 32'h22222222);
    cyc();
    valid = 1'b0; prdata = 32'h22222222;
    #1;
    chk("b2b_setup2_psel", 64'(psel), 64'h1);
    chk("b2b_setup2_penable", 64'(penable), 64'd0);
    chk("b2b_setup2_paddr", 64'(paddr), 64'h34);
    cyc(); #1;
    chk("b2b_access2_hrdata", 64'(hrdata), 64'h22222222);
    cyc();

    // Slave error
    valid = 1'b1; haddr = 32'h40; slvsel = 3'b010;
    push(1'b1, 1'b0, 32'h0);
    cyc();
    valid = 1'b0; pslverr = 1'b1; pready = 1'b1;
    cyc(); #1;
    chk("err_access_hready", 64'(hreadyout), 64'd0);
    chk("err_access_hresp", 64'(hresp), 64'd0);
    cyc();
    pslverr = 1'b0;
    #1;
    chk("err1_hresp", 64'(hresp), 64'd1);
    chk("err1_hready", 64'(hreadyout), 64'd0);
    chk("err1_psel", 64'(psel), 64'd0);
    cyc(); #1;
    chk("err2_hresp", 64'(hresp), 64'd1);
    chk("err2_hready", 64'(hreadyout), 64'd1);
    cyc(); #1;
    chk("err_idle_hresp", 64'(hresp), 64'd0);
    chk("err_idle_hready", 64'(hreadyout), 64'd1);

    // Bad decode: two bits set, then zero bits accepted straight from ERR2
    valid = 1'b1; slvsel = 3'b011;
    push(1'b1, 1'b0, 32'h0);
    cyc();
    valid = 1'b0;
    #1;
    chk("dec011_err1_hresp", 64'(hresp), 64'd1);
    chk("dec011_err1_psel", 64'(psel), 64'd0);
    cyc();
    valid = 1'b1; slvsel = 3'b000;
    #1;
    chk("dec011_err2_psel", 64'(psel), 64'd0);
    push(1'b1, 1'b0, 32'h0);
    cyc();
    valid = 1'b0;
    #1;
    chk("dec000_err1_hready", 64'(hreadyout), 64'd0);
    chk("dec000_err1_psel", 64'(psel), 64'd0);
    cyc(); cyc(); #1;
    chk("dec_idle_hresp", 64'(hresp), 64'd0);

    // Reset during ACCESS aborts without a response
    valid = 1'b1; haddr = 32'h50; slvsel = 3'b001; pready = 1'b0;
    cyc();
    valid = 1'b0;
    cyc(); #1;
    chk("rst_mid_penable", 64'(penable), 64'd1);
    hreset = 1'b1;
    cyc(); #1;
    chk("rst_mid_psel", 64'(psel), 64'd0);
    chk("rst_mid_penable0", 64'(penable), 64'd0);
    chk("rst_mid_hready", 64'(hreadyout), 64'd1);
    hreset = 1'b0;
    cyc();

`ifdef APB_TIMEOUT_EN
    valid = 1'b1; haddr = 32'h60; slvsel = 3'b100; pready = 1'b0;
    push(1'b1, 1'b0, 32'h0);
    cyc();
    valid = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_access_penable", 64'(penable), 64'd1);
      chk("to_access_hready", 64'(hreadyout), 64'd0);
      cyc();
    end
    #1;
    chk("to_err1_hresp", 64'(hresp), 64'd1);
    chk("to_err1_psel", 64'(psel), 64'd0);
    cyc(); cyc();
`endif

    cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
